// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the serial key loader.
package rll_key_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CHECK,
      ARMED,
      LOCKOUT
   } state_e;

   localparam int FAIL_CNT_W = 4;
   localparam int PAR_VEC_W  = 257;

   // Callers zero-pad to PAR_VEC_W; the padding never changes the result.
   function automatic logic even_parity(input logic [PAR_VEC_W-1:0] v);
      return ~^v;
   endfunction

endpackage

// File: rtl/rll_key_shreg.sv
// Indexed-write beat register: each write lands at the current beat index.
module rll_key_shreg #(
   parameter int W = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       wr_en,
   input  logic       bit_in,
   output logic [W:0] data,
   output logic       full
);

   localparam int CW = $clog2(W + 2);

   logic [W:0]    data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (wr_en) begin
         for (int i = 0; i <= W; i++) begin
            if (cnt_q == CW'(i)) data_d[i] = bit_in;
         end
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data = data_q;
   // All key bits are in; the next beat is the parity bit.
   assign full = (cnt_q == CW'(W));

endmodule

// File: rtl/rll_key_loader.sv
// Serial key loader: shifts in key + parity, arms the locked netlist's key bus,
// and locks out after repeated parity failures.
module rll_key_loader
   import rll_key_pkg::*;
#(
   parameter int                  KEY_WIDTH = 16,
   parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
   parameter int                  MAX_FAILS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_bit,
   input  logic                  key_valid,
   output logic                  key_ready,
   input  logic                  clear,
   output logic [KEY_WIDTH-1:0]  key_out,
   output logic                  key_armed,
   output logic [FAIL_CNT_W-1:0] fail_cnt,
   output logic                  locked_out
);

   state_e                  state_q, state_d;
   logic [KEY_WIDTH-1:0]    key_out_q, key_out_d;
   logic                    key_armed_q, key_armed_d;
   logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic                    locked_q, locked_d;

   logic                    beat;
   logic                    load_clr;
   logic                    sh_wr;
   logic                    sh_clr;
   logic                    sh_full;
   logic [KEY_WIDTH:0]      sh_data;
   logic [PAR_VEC_W-1:0]    par_vec;
   logic                    par_ok;

   assign key_ready = (state_q == IDLE) || (state_q == LOAD);
   assign beat      = key_valid && key_ready;
   assign load_clr  = (state_q == LOAD) && clear;
   assign sh_wr     = beat && !load_clr;
   assign sh_clr    = load_clr || (state_q == CHECK);

   rll_key_shreg #(
      .W(KEY_WIDTH)
   ) u_shreg (
      .clk   (clk),
      .rst   (rst),
      .clr   (sh_clr),
      .wr_en (sh_wr),
      .bit_in(key_bit),
      .data  (sh_data),
      .full  (sh_full)
   );

   always_comb begin
      par_vec              = '0;
      par_vec[KEY_WIDTH:0] = sh_data;
      par_ok               = even_parity(par_vec);
   end

   always_comb begin
      state_d     = state_q;
      key_out_d   = key_out_q;
      key_armed_d = key_armed_q;
      fail_cnt_d  = fail_cnt_q;
      locked_d    = locked_q;
      unique case (state_q)
         IDLE: begin
            if (beat) state_d = LOAD;
         end
         LOAD: begin
            if (clear) state_d = IDLE;
            else if (beat && sh_full) state_d = CHECK;
         end
         CHECK: begin
            if (par_ok) begin
               state_d     = ARMED;
               key_out_d   = sh_data[KEY_WIDTH-1:0];
               key_armed_d = 1'b1;
            end else begin
               fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
               if (int'(fail_cnt_q) + 1 >= MAX_FAILS) begin
                  state_d  = LOCKOUT;
                  locked_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         ARMED: begin
            if (clear) begin
               state_d     = IDLE;
               key_out_d   = DECOY_KEY;
               key_armed_d = 1'b0;
            end
         end
         LOCKOUT: begin
            state_d = LOCKOUT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         key_out_q   <= DECOY_KEY;
         key_armed_q <= 1'b0;
         fail_cnt_q  <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_out_q   <= key_out_d;
         key_armed_q <= key_armed_d;
         fail_cnt_q  <= fail_cnt_d;
         locked_q    <= locked_d;
      end
   end

   assign key_out    = key_out_q;
   assign key_armed  = key_armed_q;
   assign fail_cnt   = fail_cnt_q;
   assign locked_out = locked_q;

endmodule

// File: tb/tb_rll_key_loader.sv
// Randomized scoreboard bench for rll_key_loader against a beat-count model.
module tb_rll_key_loader;

   localparam int             KW    = 16;
   localparam int             MF    = 3;
   localparam logic [KW-1:0]  DECOY = 16'h0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_bit = 1'b0;
   logic          key_valid = 1'b0;
   logic          clear = 1'b0;
   logic          key_ready;
   logic [KW-1:0] key_out;
   logic          key_armed;
   logic [3:0]    fail_cnt;
   logic          locked_out;

   rll_key_loader #(
      .KEY_WIDTH(KW),
      .DECOY_KEY(DECOY),
      .MAX_FAILS(MF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_bit   (key_bit),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .clear     (clear),
      .key_out   (key_out),
      .key_armed (key_armed),
      .fail_cnt  (fail_cnt),
      .locked_out(locked_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [KW-1:0] ko;
      logic          armed;
      logic          ready;
      logic [3:0]    fc;
      logic          lo;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Model: beats collected so far, a pending-check flag, and outcome flags.
   int            m_nbits;
   logic [KW:0]   m_bits;
   bit            m_chk, m_armed, m_locked;
   int            m_fails;
   logic [KW-1:0] m_kout;

   task automatic model(input logic r, input logic v,
                        input logic b, input logic c);
      if (r) begin
         m_nbits = 0; m_bits = '0; m_chk = 0; m_armed = 0;
         m_locked = 0; m_fails = 0; m_kout = DECOY;
      end else if (m_locked) begin
      end else if (m_chk) begin
         if ((^m_bits) == 1'b0) begin
            m_armed = 1;
            m_kout  = m_bits[KW-1:0];
         end else begin
            m_fails++;
            if (m_fails == MF) m_locked = 1;
         end
         m_chk = 0; m_nbits = 0; m_bits = '0;
      end else if (m_armed) begin
         if (c) begin
            m_armed = 0;
            m_kout  = DECOY;
         end
      end else if (c && m_nbits > 0) begin
         m_nbits = 0; m_bits = '0;
      end else if (v) begin
         m_bits[m_nbits] = b;
         m_nbits++;
         if (m_nbits == KW + 1) m_chk = 1;
      end
   endtask

   function automatic exp_t expected();
      exp_t e;
      e.ko    = m_kout;
      e.armed = m_armed;
      e.ready = !(m_locked || m_chk || m_armed);
      e.fc    = 4'(m_fails);
      e.lo    = m_locked;
      return e;
   endfunction

   task automatic step(input logic r, input logic v,
                       input logic b, input logic c);
      rst = r; key_valid = v; key_bit = b; clear = c;
      @(posedge clk);
      model(r, v, b, c);
      q.push_back(expected());
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send(input logic [KW-1:0] k, input logic par,
                       input bit gaps);
      logic [KW:0] w;
      w = {par, k};
      for (int i = 0; i <= KW; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) idle(1);
         step(1'b0, 1'b1, w[i], 1'b0);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (q.size() > 0) begin
         e = q.pop_front();
         vectors++;
         if ({key_out, key_armed, key_ready, fail_cnt, locked_out} !== e) begin
            miscompares++;
            $display("FAIL outputs cyc=%0d got ko=%h arm=%b rdy=%b fc=%0d lo=%b exp ko=%h arm=%b rdy=%b fc=%0d lo=%b",
                     cyc, key_out, key_armed, key_ready, fail_cnt, locked_out,
                     e.ko, e.armed, e.ready, e.fc, e.lo);
         end
      end
   end

   initial begin
      logic [KW-1:0] k;
      logic          p;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      idle(2);
      // good key back-to-back, then disarm
      send(16'hA5C3, 1'b0, 0);
      idle(3);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      // bad parity
      send(16'hA5C3, 1'b1, 0);
      idle(3);
      // clear mid-load, then fresh good load
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      send(16'h1234, 1'b1, 0);
      idle(3);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      // two more bad loads reach lockout; further load and clear ignored
      send(16'h00FF, 1'b1, 1);
      idle(2);
      send(16'h0F0F, 1'b1, 0);
      idle(2);
      send(16'hA5C3, 1'b0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      // armed, clear, then rst on 10th bit of a new load
      send(16'hA5C3, 1'b0, 0);
      idle(3);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      send(16'h1234, 1'b1, 0);
      idle(3);
      // random keys with mostly-correct parity
      for (int n = 0; n < 25; n++) begin
         k = 16'($urandom);
         p = (^k) ^ ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) step(1'b1, 1'b0, 1'b0, 1'b0);
         send(k, p, 1);
         idle($urandom_range(1, 3));
         step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
      // fully random pin activity
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 79) == 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom),
              1'($urandom_range(0, 24) == 0));
      end
      idle(2);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain left=%0d required=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
